// File: rtl/macguffin_pkg.sv
// Shared types for the MacGuffin P-box pipeline: the 48-bit S-box-input bit map,
// map helpers (inverse, bijection check) and the stage record.
package macguffin_pkg;

    localparam int PBOX_W  = 48;
    localparam int MAP_MAX = 256;

    typedef logic [7:0]                bit_idx_t;
    typedef bit_idx_t [MAP_MAX-1:0]    pmap_t;
    typedef bit_idx_t [PBOX_W-1:0]     pbox48_map_t;

    typedef struct packed {
        logic              vld;
        logic              inv;
        logic [PBOX_W-1:0] dat;
    } stage_rec_t;

    // Per S-box input taps: two bits from each 16-bit word a, b, c (word bit 0 = word MSB).
    localparam logic [0:47][3:0] SBOX_TAPS = {
        4'd2,  4'd5,  4'd6,  4'd9,  4'd11, 4'd13,
        4'd1,  4'd4,  4'd7,  4'd10, 4'd8,  4'd14,
        4'd3,  4'd6,  4'd8,  4'd13, 4'd0,  4'd15,
        4'd12, 4'd14, 4'd1,  4'd2,  4'd4,  4'd10,
        4'd0,  4'd10, 4'd3,  4'd14, 4'd6,  4'd12,
        4'd7,  4'd8,  4'd12, 4'd15, 4'd1,  4'd5,
        4'd9,  4'd15, 4'd5,  4'd11, 4'd2,  4'd7,
        4'd11, 4'd13, 4'd0,  4'd4,  4'd3,  4'd9
    };

    // Word a occupies the top 16 bits; S-box 1 lands in the top 6 output bits,
    // first-listed tap at the low end of each 6-bit group.
    function automatic pbox48_map_t build_pbox48();
        pbox48_map_t m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 6; j++) begin
                m[6*(7-b)+j] = bit_idx_t'(PBOX_W - 1 - 16*(j/2) - int'(SBOX_TAPS[6*b+j]));
            end
        end
        return m;
    endfunction

    localparam pbox48_map_t PBOX48_MAP = build_pbox48();

    function automatic pmap_t invert_map(input pmap_t fwd, input int w);
        pmap_t inv;
        inv = '0;
        for (int i = 0; i < w; i++) begin
            inv[fwd[i]] = bit_idx_t'(i);
        end
        return inv;
    endfunction

    function automatic bit map_is_bijection(input pmap_t m, input int w);
        logic [MAP_MAX-1:0] seen;
        bit                 ok;
        seen = '0;
        ok   = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (int'(m[i]) >= w || seen[m[i]]) begin
                ok = 1'b0;
            end
            seen[m[i]] = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/macguffin_pipe_stage.sv
// One register slice holding a {valid, inv, data} record.
// Latency 1 cycle; loads when empty or when its contents leave the same cycle.
// Backpressure: up_rdy depends only on own valid and dn_rdy, never on up_rec.vld.
module macguffin_pipe_stage
    import macguffin_pkg::*;
#(
    parameter type rec_t = macguffin_pkg::stage_rec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  rec_t up_rec,
    output logic up_rdy,
    output rec_t dn_rec,
    input  logic dn_rdy
);

    rec_t rec_q;
    rec_t rec_d;

    always_comb begin
        up_rdy = !rec_q.vld || dn_rdy;
        rec_d  = rec_q;
        if (up_rdy) begin
            // A bubble only clears valid so idle cycles leave the data flops untouched.
            if (up_rec.vld) begin
                rec_d = up_rec;
            end else begin
                rec_d.vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign dn_rec = rec_q;

endmodule

// File: rtl/macguffin_perm_pipe.sv
// Bit-permutation pipeline (default MacGuffin P-box), inverse mode under MACGUFFIN_PERM_INV_EN.
// Latency STAGES cycles from acceptance, one word per cycle with out_ready high.
// Backpressure: out_ready low stalls every full stage in place; in_ready drops once stage 0 cannot drain.
module macguffin_perm_pipe
    import macguffin_pkg::*;
#(
    parameter int                      WIDTH    = 48,
    parameter int                      STAGES   = 2,
    parameter logic [WIDTH-1:0][7:0]   PERM_MAP = macguffin_pkg::PBOX48_MAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_inv
);

    typedef struct packed {
        logic             vld;
        logic             inv;
        logic [WIDTH-1:0] dat;
    } rec_t;

    localparam pmap_t FWD_MAP = pmap_t'(PERM_MAP);

    if (WIDTH < 1 || WIDTH > MAP_MAX) begin : g_bad_width
        $error("macguffin_perm_pipe: WIDTH must be 1..256");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("macguffin_perm_pipe: STAGES must be 1..4");
    end
    if (!map_is_bijection(FWD_MAP, WIDTH)) begin : g_bad_map
        $error("macguffin_perm_pipe: PERM_MAP is not a bijection on 0..WIDTH-1");
    end

    // Permutation is pure wiring in front of stage 0; later stages only delay.
    logic [WIDTH-1:0] fwd_dat;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fwd
        localparam int SRC = int'(FWD_MAP[i]);
        assign fwd_dat[i] = in_data[SRC];
    end

    rec_t s0_rec;
    rec_t chain [STAGES+1];
    logic rdy   [STAGES+1];

`ifdef MACGUFFIN_PERM_INV_EN
    localparam pmap_t INV_MAP = invert_map(FWD_MAP, WIDTH);

    logic [WIDTH-1:0] inv_dat;
    for (genvar i = 0; i < WIDTH; i++) begin : g_inv
        localparam int SRC = int'(INV_MAP[i]);
        assign inv_dat[i] = in_data[SRC];
    end

    always_comb begin
        s0_rec     = '0;
        s0_rec.vld = in_valid;
        s0_rec.inv = in_inv;
        s0_rec.dat = in_inv ? inv_dat : fwd_dat;
    end

    assign out_inv = chain[STAGES].inv;
`else
    logic unused_inv;

    always_comb begin
        s0_rec     = '0;
        s0_rec.vld = in_valid;
        s0_rec.inv = 1'b0;
        s0_rec.dat = fwd_dat;
    end

    assign out_inv    = 1'b0;
    assign unused_inv = in_inv ^ chain[STAGES].inv;
`endif

    assign chain[0]    = s0_rec;
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        macguffin_pipe_stage #(
            .rec_t (rec_t)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .up_rec (chain[k]),
            .up_rdy (rdy[k]),
            .dn_rec (chain[k+1]),
            .dn_rdy (rdy[k+1])
        );
    end

    // Stage valids are already clear in reset; the gate also keeps in_ready low there.
    assign in_ready  = rst_n & rdy[0];
    assign out_valid = chain[STAGES].vld;
    assign out_data  = chain[STAGES].dat;

endmodule

// File: tb/tb_macguffin_perm_pipe.sv
// Directed bench for macguffin_perm_pipe: reset, latency, walking one/zero,
// backpressure, mid-stream reset and a 1000-word forward/inverse round trip.
`timescale 1ns/1ps
module tb_macguffin_perm_pipe;

    localparam int W      = 48;
    localparam int STAGES = 2;

`ifdef MACGUFFIN_PERM_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_inv    = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_inv;
    logic [W-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int cyc     = 0;

    logic [W:0]   exp_q [$];
    logic [W-1:0] got_q [$];
    logic [W-1:0] fwd_q [$];
    logic [W-1:0] orig  [1000];
    logic [W-1:0] bp    [8];

    // Output bit position of each source bit, derived by hand from the S-box tap table.
    int fwd_pos [W] = '{35, 41, 47, 23, 46, 29,  5, 40, 11, 22, 17, 28,
                         4, 10, 16, 34, 15, 21, 33, 14,  9, 39, 45, 32,
                        38, 44,  8,  3, 20, 27, 26,  2,  7, 25,  1, 24,
                         0, 19,  6, 13, 12, 31, 43, 37, 30, 42, 36, 18};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    macguffin_perm_pipe #(
        .WIDTH  (W),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_inv   (out_inv)
    );

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int s = 0; s < W; s++) begin
            if (INV_EN && inv) r[s] = x[fwd_pos[s]];
            else               r[fwd_pos[s]] = x[s];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the word is taken.
    task automatic send(input logic [W-1:0] d, input logic inv);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        else           exp_q.push_back({inv && INV_EN, model(d, inv)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    logic       mon_stall = 1'b0;
    logic [W:0] mon_held;
    logic [W:0] mon_exp;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    chk("hold_vld", 64'(out_valid), 64'd1);
                    chk("hold_dat", 64'({out_inv, out_data}), 64'(mon_held));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 64'(out_valid), 64'd0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("out_dat", 64'(out_data), 64'(mon_exp[W-1:0]));
                        chk("out_inv", 64'(out_inv), 64'(mon_exp[W]));
                        got_q.push_back(out_data);
                        n_out++;
                    end
                end
                mon_stall = out_valid && !out_ready;
                mon_held  = {out_inv, out_data};
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [W-1:0] one;
        int           lat;
        int           acc;
        int           idx;
        int           base;
        int           c0;

        one = 1;

        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_inv",   64'(out_inv),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency and the forward walking-one vector
        out_ready = 1'b1;
        send(48'h0000_0000_0001, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk("latency", 64'(lat), 64'(STAGES));
        chk("walk1_k0", 64'(out_data), 64'h0008_0000_0000);
        @(posedge clk);
        #1;
        drain();

        // Walking one, walking zero and inverse, mixed back-to-back
        for (int k = 0; k < W; k++) begin
            send(one << k, 1'b0);
            send(~(one << k), 1'b0);
            send(one << fwd_pos[k], 1'b1);
        end
        drain();

        // Backpressure with 8 distinct words
        for (int i = 0; i < 8; i++) bp[i] = W'(48'h1111_2222_3333 * (i + 1));
        base = n_out;
        for (int i = 0; i < 3; i++) send(bp[i], 1'b0);
        drain();
        out_ready = 1'b0;
        acc       = 0;
        idx       = 3;
        in_valid  = 1'b1;
        in_inv    = 1'b0;
        in_data   = bp[idx];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({1'b0, model(bp[idx], 1'b0)});
                idx++;
                acc++;
            end
            @(posedge clk);
            #1;
            if (idx < 8) in_data = bp[idx];
            else         in_valid = 1'b0;
        end
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_accepts", 64'(acc), 64'(STAGES));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (idx < 8) begin
            send(bp[idx], 1'b0);
            idx++;
        end
        drain();
        chk("bp_count", 64'(n_out - base), 64'd8);

        // Reset with two words in flight
        out_ready = 1'b0;
        send(48'hDEAD_BEEF_0001, 1'b0);
        send(48'h0123_4567_89AB, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready",  64'(in_ready),  64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_rel_ready", 64'(in_ready), 64'd1);
        chk("mrst_out_data",  64'(out_data), 64'd0);
        out_ready = 1'b1;
        base      = n_out;
        repeat (10) @(posedge clk);
        #1;
        chk("mrst_no_stale", 64'(n_out - base), 64'd0);

        // Round trip: forward, then results fed back as inverse
        for (int i = 0; i < 1000; i++) orig[i] = W'({$urandom(), $urandom()});
        got_q.delete();
        c0 = cyc;
        for (int i = 0; i < 1000; i++) send(orig[i], 1'b0);
        chk("throughput_cycles", 64'(cyc - c0), 64'd1000);
        drain();
        fwd_q = got_q;
        got_q.delete();
        for (int i = 0; i < 1000; i++) send(fwd_q[i], 1'b1);
        drain();
        chk("rt_count", 64'(got_q.size()), 64'd1000);
`ifdef MACGUFFIN_PERM_INV_EN
        for (int i = 0; i < 1000; i++) chk("rt_orig", 64'(got_q[i]), 64'(orig[i]));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/macguffin_perm_pipe.md
MACGUFFIN_PERM_PIPE -- requirements
Module: macguffin_perm_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 48, permuted word width in bits.
REQ-002 SHALL have parameter STAGES, default 2, register stages from input to output (range 1..4).
REQ-003 SHALL have parameter PERM_MAP, default macguffin_pkg::PBOX48_MAP, giving the source-bit index for each output bit.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1, input word offered.
REQ-007 SHALL have port in_ready, output, 1, input word accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data, input, WIDTH, word to permute.
REQ-009 SHALL have port in_inv, input, 1, per-word mode: 0 forward, 1 inverse permutation.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts when out_valid && out_ready.
REQ-012 SHALL have port out_data, output, WIDTH, permuted word.
REQ-013 SHALL have port out_inv, output, 1, mode tag travelling with out_data.

Function
REQ-014 Forward: out_data[i] SHALL equal in_data[PERM_MAP[i]] for every i.
REQ-015 Inverse: out_data[PERM_MAP[i]] SHALL equal in_data[i]; inverse(forward(x)) SHALL equal x.
REQ-016 Latency SHALL be exactly STAGES cycles from acceptance to out_valid with out_ready held high.
REQ-017 Throughput SHALL be one word per cycle with out_ready held high.
REQ-018 Each stage SHALL hold valid, data and mode tag, and SHALL load when empty or when its contents advance the same cycle (bubble collapse).
REQ-019 in_ready SHALL be high when stage 0 is empty or stage 0 advances that cycle; in_ready SHALL NOT depend combinationally on in_valid.
REQ-020 With out_ready low and all stages full, in_ready SHALL be low and every stage SHALL hold its contents unchanged.
REQ-021 out_valid SHALL stay high and out_data/out_inv SHALL stay stable until the handshake completes.
REQ-022 Simultaneous accept and emit on a full pipe SHALL lose and duplicate no word.
REQ-023 Words SHALL leave in acceptance order with their mode tags; mixed forward/inverse streams SHALL be legal back-to-back.
REQ-024 Permutation logic SHALL sit before stage 0's register; later stages only delay.
REQ-025 PERM_MAP SHALL be a bijection on 0..WIDTH-1; elaboration SHALL fail if it is not.

Reset
REQ-026 rst_n low SHALL immediately clear all stage valid bits; out_valid=0, in_ready=0 while rst_n is low.
REQ-027 Data and tag registers SHALL reset to 0; out_data=0, out_inv=0 after reset.
REQ-028 Reset mid-stream SHALL discard all in-flight words; in_ready SHALL return high in the first cycle after release.

Configuration
REQ-029 Macro MACGUFFIN_PERM_INV_EN defined: inverse mode SHALL be built per REQ-015.
REQ-030 Macro MACGUFFIN_PERM_INV_EN undefined: in_inv SHALL be ignored, all words SHALL be forward-permuted, out_inv SHALL be tied to 0, and no inverse mux logic SHALL be generated.

Structure
REQ-031 macguffin_pkg SHALL hold PBOX48_MAP (the 48-bit MacGuffin S-box-input permutation), a function that builds the inverse map, and a stage record typedef (valid, data, inv).
REQ-032 The pipeline SHALL use one sub-module, macguffin_pipe_stage, instantiated STAGES times via generate.

Verification
REQ-033 Walking one, forward: in_data=48'h0000_0000_0001, in_inv=0 -> out_data=48'h0008_0000_0000 after STAGES cycles.
REQ-034 Walking one, inverse (INV_EN): in_data=48'h0008_0000_0000, in_inv=1 -> out_data=48'h0000_0000_0001.
REQ-035 Walking zero: in_data=~(48'h1<<k) for k=0..47 forward -> out_data equals the bitwise complement of the walking-one result for k.
REQ-036 Backpressure: stream 8 distinct words, hold out_ready=0 for 5 cycles mid-stream -> in_ready falls after STAGES extra accepts, 8 outputs in order with no loss or duplicates.
REQ-037 Round trip: 1000 random words forward, results fed back with in_inv=1 -> outputs equal the originals; out_inv matches each tag.
REQ-038 Reset mid-stream: rst_n low for 1 cycle with 2 words in flight -> out_valid=0 immediately, no stale word emitted after release.
